// File: rtl/rs_issue_queue_if.sv
// rtl/rs_issue_queue_if.sv - dispatch, CDB, selector and issue signal bundle for rs_issue_queue
// RS_FREE_CNT_EN adds the free_cnt status output.
interface rs_issue_queue_if #(
  parameter int RS_SIZE   = 16,
  parameter int XLEN      = 32,
  parameter int TAG_W     = 6,
  parameter int CDB_W     = 2,
  parameter int PAYLOAD_W = 32
);
  logic                      squash;
  logic                      disp_valid;
  logic [XLEN-1:0]           disp_pc;
  logic [TAG_W-1:0]          disp_dest;
  logic [TAG_W-1:0]          disp_src1;
  logic [TAG_W-1:0]          disp_src2;
  logic                      disp_rdy1;
  logic                      disp_rdy2;
  logic [PAYLOAD_W-1:0]      disp_payload;
  logic [CDB_W-1:0]          cdb_valid;
  logic [CDB_W*TAG_W-1:0]    cdb_tag;
  logic                      issue_stall;
  logic [RS_SIZE-1:0]        sel_req;
  logic [RS_SIZE*XLEN-1:0]   sel_pc;
  logic                      sel_en;
  logic [RS_SIZE-1:0]        sel_gnt;
  logic                      rs_full;
  logic                      issue_valid;
  logic [XLEN-1:0]           issue_pc;
  logic [TAG_W-1:0]          issue_dest;
  logic [PAYLOAD_W-1:0]      issue_payload;
`ifdef RS_FREE_CNT_EN
  logic [$clog2(RS_SIZE+1)-1:0] free_cnt;

  modport master (
    output squash, disp_valid, disp_pc, disp_dest, disp_src1, disp_src2,
           disp_rdy1, disp_rdy2, disp_payload, cdb_valid, cdb_tag,
           issue_stall, sel_gnt,
    input  sel_req, sel_pc, sel_en, rs_full, issue_valid, issue_pc,
           issue_dest, issue_payload, free_cnt
  );

  modport slave (
    input  squash, disp_valid, disp_pc, disp_dest, disp_src1, disp_src2,
           disp_rdy1, disp_rdy2, disp_payload, cdb_valid, cdb_tag,
           issue_stall, sel_gnt,
    output sel_req, sel_pc, sel_en, rs_full, issue_valid, issue_pc,
           issue_dest, issue_payload, free_cnt
  );
`else
  modport master (
    output squash, disp_valid, disp_pc, disp_dest, disp_src1, disp_src2,
           disp_rdy1, disp_rdy2, disp_payload, cdb_valid, cdb_tag,
           issue_stall, sel_gnt,
    input  sel_req, sel_pc, sel_en, rs_full, issue_valid, issue_pc,
           issue_dest, issue_payload
  );

  modport slave (
    input  squash, disp_valid, disp_pc, disp_dest, disp_src1, disp_src2,
           disp_rdy1, disp_rdy2, disp_payload, cdb_valid, cdb_tag,
           issue_stall, sel_gnt,
    output sel_req, sel_pc, sel_en, rs_full, issue_valid, issue_pc,
           issue_dest, issue_payload
  );
`endif
endinterface

// File: rtl/rs_issue_queue.sv
// rtl/rs_issue_queue.sv - 16-entry reservation station with CDB wakeup feeding an oldest-PC selector
// RS_FREE_CNT_EN adds a registered free-entry counter.
module rs_issue_queue #(
  parameter int RS_SIZE   = 16,
  parameter int XLEN      = 32,
  parameter int TAG_W     = 6,
  parameter int CDB_W     = 2,
  parameter int PAYLOAD_W = 32
) (
  input  logic             i_clock,
  input  logic             i_reset,
  rs_issue_queue_if.slave  bus
);
  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0]   r_valid;
  logic [RS_SIZE-1:0]   r_rdy1;
  logic [RS_SIZE-1:0]   r_rdy2;
  logic [XLEN-1:0]      r_pc      [RS_SIZE];
  logic [TAG_W-1:0]     r_dest    [RS_SIZE];
  logic [TAG_W-1:0]     r_src1    [RS_SIZE];
  logic [TAG_W-1:0]     r_src2    [RS_SIZE];
  logic [PAYLOAD_W-1:0] r_payload [RS_SIZE];

  logic                 r_issue_valid;
  logic [XLEN-1:0]      r_issue_pc;
  logic [TAG_W-1:0]     r_issue_dest;
  logic [PAYLOAD_W-1:0] r_issue_payload;

  logic [RS_SIZE-1:0]      w_req;
  logic                    w_sel_en;
  logic                    w_full;
  logic [RS_SIZE-1:0]      w_gnt_ok;
  logic                    w_gnt_any;
  logic [IDX_W-1:0]        w_gnt_idx;
  logic [RS_SIZE-1:0]      w_alloc_oh;
  logic                    w_do_alloc;
  logic [RS_SIZE-1:0]      w_wake1;
  logic [RS_SIZE-1:0]      w_wake2;
  logic                    w_d_rdy1;
  logic                    w_d_rdy2;
  logic [RS_SIZE-1:0]      w_valid_nxt;
  logic [RS_SIZE*XLEN-1:0] w_sel_pc;

  function automatic logic f_cdb_hit(
    input logic [TAG_W-1:0]       tag,
    input logic [CDB_W-1:0]       cvalid,
    input logic [CDB_W*TAG_W-1:0] ctags
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < CDB_W; k++) begin
      if (cvalid[k] && (ctags[k*TAG_W +: TAG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  assign w_req      = r_valid & r_rdy1 & r_rdy2;
  assign w_sel_en   = ~bus.issue_stall & ~bus.squash;
  assign w_full     = &r_valid;
  // Grant bits on entries that are not requesting are ignored outright.
  assign w_gnt_ok   = bus.sel_gnt & w_req & {RS_SIZE{w_sel_en}};
  assign w_gnt_any  = |w_gnt_ok;
  assign w_do_alloc = bus.disp_valid & ~w_full & ~bus.squash;
  assign w_alloc_oh = ~r_valid & (r_valid + RS_SIZE'(1));

  assign w_d_rdy1 = bus.disp_rdy1 | (bus.disp_src1 == '0) |
                    f_cdb_hit(bus.disp_src1, bus.cdb_valid, bus.cdb_tag);
  assign w_d_rdy2 = bus.disp_rdy2 | (bus.disp_src2 == '0) |
                    f_cdb_hit(bus.disp_src2, bus.cdb_valid, bus.cdb_tag);

  always_comb begin
    w_gnt_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (w_gnt_ok[i]) w_gnt_idx = IDX_W'(i);
    end
  end

  always_comb begin
    w_wake1 = '0;
    w_wake2 = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      w_wake1[i] = f_cdb_hit(r_src1[i], bus.cdb_valid, bus.cdb_tag);
      w_wake2[i] = f_cdb_hit(r_src2[i], bus.cdb_valid, bus.cdb_tag);
    end
  end

  // Allocation uses the pre-grant valid bits, so a slot freed this cycle stays unused until next cycle.
  always_comb begin
    w_valid_nxt = (r_valid & ~w_gnt_ok) | (w_do_alloc ? w_alloc_oh : '0);
    if (bus.squash) w_valid_nxt = '0;
  end

  always_comb begin
    w_sel_pc = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      w_sel_pc[i*XLEN +: XLEN] = r_valid[i] ? r_pc[i] : '0;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_valid <= '0;
      r_rdy1  <= '0;
      r_rdy2  <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        r_pc[i]      <= '0;
        r_dest[i]    <= '0;
        r_src1[i]    <= '0;
        r_src2[i]    <= '0;
        r_payload[i] <= '0;
      end
    end else begin
      r_valid <= w_valid_nxt;
      r_rdy1  <= r_rdy1 | w_wake1;
      r_rdy2  <= r_rdy2 | w_wake2;
      for (int i = 0; i < RS_SIZE; i++) begin
        if (w_do_alloc && w_alloc_oh[i]) begin
          r_pc[i]      <= bus.disp_pc;
          r_dest[i]    <= bus.disp_dest;
          r_src1[i]    <= bus.disp_src1;
          r_src2[i]    <= bus.disp_src2;
          r_payload[i] <= bus.disp_payload;
          r_rdy1[i]    <= w_d_rdy1;
          r_rdy2[i]    <= w_d_rdy2;
        end
      end
    end
  end

  // A stalled issue register holds its packet; otherwise it takes the winner or goes empty.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_issue_valid   <= 1'b0;
      r_issue_pc      <= '0;
      r_issue_dest    <= '0;
      r_issue_payload <= '0;
    end else if (bus.squash) begin
      r_issue_valid <= 1'b0;
    end else if (w_gnt_any) begin
      r_issue_valid   <= 1'b1;
      r_issue_pc      <= r_pc[w_gnt_idx];
      r_issue_dest    <= r_dest[w_gnt_idx];
      r_issue_payload <= r_payload[w_gnt_idx];
    end else if (!bus.issue_stall) begin
      r_issue_valid <= 1'b0;
    end
  end

  assign bus.sel_req       = w_req;
  assign bus.sel_pc        = w_sel_pc;
  assign bus.sel_en        = w_sel_en;
  assign bus.rs_full       = w_full;
  assign bus.issue_valid   = r_issue_valid;
  assign bus.issue_pc      = r_issue_pc;
  assign bus.issue_dest    = r_issue_dest;
  assign bus.issue_payload = r_issue_payload;

`ifdef RS_FREE_CNT_EN
  localparam int CNT_W = $clog2(RS_SIZE + 1);

  logic [CNT_W-1:0] r_free_cnt;
  logic [CNT_W-1:0] w_free_nxt;

  always_comb begin
    w_free_nxt = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!w_valid_nxt[i]) w_free_nxt = w_free_nxt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_free_cnt <= CNT_W'(RS_SIZE);
    else         r_free_cnt <= w_free_nxt;
  end

  assign bus.free_cnt = r_free_cnt;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      assert ($countones(bus.sel_gnt & w_req) <= 1)
        else $error("rs_issue_queue: more than one requesting entry granted");
    end
  end
`endif
endmodule
